// File: rtl/sync_fifo_if.sv
// sync_fifo_if: handshake bundle between a sync_fifo and its user.
//   master : user side   (drives w_en, wdata, r_en [, err_clr])
//   slave  : FIFO side   (drives full, almost_full, rdata, rvalid, empty,
//                         almost_empty, count [, overflow, underflow])
// Optional SYNC_FIFO_ERR_EN adds overflow/underflow/err_clr.
interface sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  w_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  full;
  logic                  almost_full;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
`ifdef SYNC_FIFO_ERR_EN
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;

  modport master (
    output w_en, wdata, r_en, err_clr,
    input  full, almost_full, rdata, rvalid, empty, almost_empty, count,
           overflow, underflow
  );
  modport slave (
    input  w_en, wdata, r_en, err_clr,
    output full, almost_full, rdata, rvalid, empty, almost_empty, count,
           overflow, underflow
  );
`else
  modport master (
    output w_en, wdata, r_en,
    input  full, almost_full, rdata, rvalid, empty, almost_empty, count
  );
  modport slave (
    input  w_en, wdata, r_en,
    output full, almost_full, rdata, rvalid, empty, almost_empty, count
  );
`endif
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH = 2**ADDR_WIDTH entries.
// Ports:
//   clk   : rising-edge clock for all logic
//   rst_n : asynchronous active-low reset (pointers, count, read regs)
//   fifo  : sync_fifo_if.slave (write/read handshake, status, count)
// Parameters: DATA_WIDTH, ADDR_WIDTH, AF_THRESH, AE_THRESH,
//   FWFT (1 = first-word-fall-through, 0 = registered read).
// Macro SYNC_FIFO_ERR_EN: adds sticky overflow/underflow flags cleared
//   by err_clr (a set in the same cycle as err_clr wins).
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned AF_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int unsigned AE_THRESH  = 4,
  parameter bit          FWFT       = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  sync_fifo_if.slave  fifo
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;

  // Status flags come only from the registered count.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  assign fifo.full         = full;
  assign fifo.empty        = empty;
  assign fifo.almost_full  = (count_q >= AF_C);
  assign fifo.almost_empty = (count_q <= AE_C);
  assign fifo.count        = count_q;

  assign wr_acc = fifo.w_en && !full;
  assign rd_acc = fifo.r_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= fifo.wdata;
  end

  generate
    if (FWFT) begin : g_fwft
      assign fifo.rdata  = mem_q[rd_ptr_q];
      assign fifo.rvalid = !empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
      logic                  rvalid_q, rvalid_d;

      always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (rd_acc) begin
          rdata_d  = mem_q[rd_ptr_q];
          rvalid_d = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign fifo.rdata  = rdata_q;
      assign fifo.rvalid = rvalid_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (fifo.err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (fifo.w_en && full)  overflow_d  = 1'b1;
    if (fifo.r_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo.overflow  = overflow_q;
  assign fifo.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with DEPTH=4, AF_THRESH=3, AE_THRESH=1.
// u_fwft runs FWFT=1 (table-driven), u_reg runs FWFT=0 (hand sequences).
module tb_sync_fifo;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) f1_if ();
  sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) f2_if ();

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1),
              .FWFT(1'b1))
    u_fwft (.clk(clk), .rst_n(rst_n), .fifo(f1_if.slave));

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1),
              .FWFT(1'b0))
    u_reg (.clk(clk), .rst_n(rst_n), .fifo(f2_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       w_en;
    logic       r_en;
    logic [7:0] wdata;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       chk_rd;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic r, logic [7:0] wd, logic [2:0] c,
                              logic fu, logic em, logic af, logic ae,
                              logic chk, logic [7:0] rd);
    vec_t v;
    v.w_en = w; v.r_en = r; v.wdata = wd; v.cnt = c;
    v.full = fu; v.empty = em; v.af = af; v.ae = ae;
    v.chk_rd = chk; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_f1(input string tag, input logic [2:0] c,
                          input logic fu, input logic em,
                          input logic af, input logic ae);
    check({tag, ".count"},        32'(f1_if.count), 32'(c));
    check({tag, ".full"},         32'(f1_if.full), 32'(fu));
    check({tag, ".empty"},        32'(f1_if.empty), 32'(em));
    check({tag, ".almost_full"},  32'(f1_if.almost_full), 32'(af));
    check({tag, ".almost_empty"}, 32'(f1_if.almost_empty), 32'(ae));
    check({tag, ".rvalid"},       32'(f1_if.rvalid), 32'(!em));
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    f1_if.w_en = 1'b0; f1_if.r_en = 1'b0; f1_if.wdata = '0;
    f2_if.w_en = 1'b0; f2_if.r_en = 1'b0; f2_if.wdata = '0;
`ifdef SYNC_FIFO_ERR_EN
    f1_if.err_clr = 1'b0;
    f2_if.err_clr = 1'b0;
`endif

    // Fill level walk, overflow, drain, underflow, empty-simultaneous
    vecs.push_back(mk(1, 0, 8'h11, 3'd1, 0, 0, 0, 1, 1, 8'h11));
    vecs.push_back(mk(1, 0, 8'h22, 3'd2, 0, 0, 0, 0, 1, 8'h11));
    vecs.push_back(mk(1, 0, 8'h33, 3'd3, 0, 0, 1, 0, 1, 8'h11));
    vecs.push_back(mk(1, 0, 8'h44, 3'd4, 1, 0, 1, 0, 1, 8'h11));
    vecs.push_back(mk(1, 0, 8'h55, 3'd4, 1, 0, 1, 0, 1, 8'h11));
    vecs.push_back(mk(0, 1, 8'h00, 3'd3, 0, 0, 1, 0, 1, 8'h22));
    vecs.push_back(mk(0, 1, 8'h00, 3'd2, 0, 0, 0, 0, 1, 8'h33));
    vecs.push_back(mk(0, 1, 8'h00, 3'd1, 0, 0, 0, 1, 1, 8'h44));
    vecs.push_back(mk(0, 1, 8'h00, 3'd0, 0, 1, 0, 1, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h00, 3'd0, 0, 1, 0, 1, 0, 8'h00));
    vecs.push_back(mk(1, 1, 8'hA5, 3'd1, 0, 0, 0, 1, 1, 8'hA5));
    vecs.push_back(mk(1, 0, 8'h01, 3'd2, 0, 0, 0, 0, 1, 8'hA5));
    // Steady state at count 2 across pointer wraps
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(1, 1, 8'(8'h02 + k), 3'd2, 0, 0, 0, 0, 1,
                        8'(8'h01 + k)));
    vecs.push_back(mk(0, 1, 8'h00, 3'd1, 0, 0, 0, 1, 1, 8'h0B));
    vecs.push_back(mk(0, 1, 8'h00, 3'd0, 0, 1, 0, 1, 0, 8'h00));

    // Reset state
    #12;
    check_f1("reset", 3'd0, 0, 1, 0, 1);
    check("reset.reg_rvalid", 32'(f2_if.rvalid), 32'd0);
    check("reset.reg_rdata",  32'(f2_if.rdata), 32'd0);
    check("reset.reg_count",  32'(f2_if.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven pass on the FWFT instance
    for (int i = 0; i < vecs.size(); i++) begin
      f1_if.w_en  = vecs[i].w_en;
      f1_if.r_en  = vecs[i].r_en;
      f1_if.wdata = vecs[i].wdata;
      tick();
      check_f1($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].full,
               vecs[i].empty, vecs[i].af, vecs[i].ae);
      if (vecs[i].chk_rd)
        check($sformatf("vec%0d.rdata", i), 32'(f1_if.rdata),
              32'(vecs[i].rd));
    end
    f1_if.w_en = 1'b0;
    f1_if.r_en = 1'b0;

`ifdef SYNC_FIFO_ERR_EN
    // Sticky flags from the dropped write and ignored reads above
    check("err.overflow_sticky",  32'(f1_if.overflow), 32'd1);
    check("err.underflow_sticky", 32'(f1_if.underflow), 32'd1);
    f1_if.err_clr = 1'b1;
    tick();
    check("err.overflow_clr",  32'(f1_if.overflow), 32'd0);
    check("err.underflow_clr", 32'(f1_if.underflow), 32'd0);
    f1_if.r_en = 1'b1;
    tick();
    check("err.set_wins",      32'(f1_if.underflow), 32'd1);
    check("err.overflow_stay", 32'(f1_if.overflow), 32'd0);
    f1_if.r_en = 1'b0;
    f1_if.err_clr = 1'b0;
    tick();
    check("err.underflow_hold", 32'(f1_if.underflow), 32'd1);
`endif

    // Registered read: one-cycle rvalid pulse
    f2_if.w_en = 1'b1; f2_if.wdata = 8'h3C;
    tick();
    f2_if.w_en = 1'b0;
    check("reg.count1",      32'(f2_if.count), 32'd1);
    check("reg.rvalid_idle", 32'(f2_if.rvalid), 32'd0);
    check("reg.rdata_idle",  32'(f2_if.rdata), 32'd0);
    f2_if.r_en = 1'b1;
    tick();
    f2_if.r_en = 1'b0;
    check("reg.rvalid_pulse", 32'(f2_if.rvalid), 32'd1);
    check("reg.rdata_pulse",  32'(f2_if.rdata), 32'h3C);
    check("reg.count0",       32'(f2_if.count), 32'd0);
    tick();
    check("reg.rvalid_drop", 32'(f2_if.rvalid), 32'd0);
    check("reg.rdata_hold",  32'(f2_if.rdata), 32'h3C);
    f2_if.r_en = 1'b1;
    tick();
    f2_if.r_en = 1'b0;
    check("reg.empty_read_rvalid", 32'(f2_if.rvalid), 32'd0);
    check("reg.empty_read_rdata",  32'(f2_if.rdata), 32'h3C);

    // Asynchronous reset mid-operation
    for (int k = 0; k < 3; k++) begin
      f1_if.w_en = 1'b1; f1_if.wdata = 8'(8'hA1 + k);
      tick();
    end
    f1_if.w_en = 1'b0;
    check("pre_rst.count", 32'(f1_if.count), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check_f1("async_rst", 3'd0, 0, 1, 0, 1);
    check("async_rst.reg_rdata",  32'(f2_if.rdata), 32'd0);
    check("async_rst.reg_rvalid", 32'(f2_if.rvalid), 32'd0);
`ifdef SYNC_FIFO_ERR_EN
    check("async_rst.underflow", 32'(f1_if.underflow), 32'd0);
`endif
    f1_if.w_en = 1'b1; f1_if.wdata = 8'hEE;
    tick();
    check("rst_held.count", 32'(f1_if.count), 32'd0);
    #3;
    rst_n = 1'b1;
    f1_if.wdata = 8'h77;
    tick();
    f1_if.w_en = 1'b0;
    check_f1("post_rst.write", 3'd1, 0, 0, 0, 1);
    check("post_rst.rdata", 32'(f1_if.rdata), 32'h77);
    f1_if.r_en = 1'b1;
    tick();
    f1_if.r_en = 1'b0;
    check_f1("post_rst.read", 3'd0, 0, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, the data word width in bits.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 6, giving DEPTH = 2^ADDR_WIDTH entries.
REQ-003 SHALL provide parameter AF_THRESH, default DEPTH-4, the almost_full assert level.
REQ-004 SHALL provide parameter AE_THRESH, default 4, the almost_empty assert level.
REQ-005 SHALL provide parameter FWFT, default 1: 1 = first-word-fall-through read, 0 = registered read.
REQ-006 SHALL have ports: clk  in  1  single clock for all logic, rising edge.
REQ-007 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: w_en  in  1  write request.
REQ-009 SHALL have ports: wdata  in  DATA_WIDTH  write data.
REQ-010 SHALL have ports: full  out  1  occupancy == DEPTH; almost_full  out  1  occupancy >= AF_THRESH.
REQ-011 SHALL have ports: r_en  in  1  read request; rdata  out  DATA_WIDTH  read data; rvalid  out  1  rdata valid.
REQ-012 SHALL have ports: empty  out  1  occupancy == 0; almost_empty  out  1  occupancy <= AE_THRESH.
REQ-013 SHALL have ports: count  out  ADDR_WIDTH+1  registered occupancy, 0..DEPTH.
REQ-014 SHALL have ports (only with SYNC_FIFO_ERR_EN): overflow  out  1; underflow  out  1; err_clr  in  1.

Function
REQ-015 Write accepted iff w_en && !full; wdata stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-016 Read accepted iff r_en && !empty; rd_ptr increments modulo DEPTH.
REQ-017 count: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write or on neither.
REQ-018 full, empty, almost_full and almost_empty SHALL be decoded from the registered count, with no path from w_en or r_en.
REQ-019 Write while full SHALL be dropped with no pointer, count or memory change; read while empty SHALL have no effect.
REQ-020 Simultaneous w_en and r_en while full: only the read is accepted; count becomes DEPTH-1.
REQ-021 Simultaneous w_en and r_en while empty: only the write is accepted; count becomes 1.
REQ-022 FWFT=1: rdata = mem[rd_ptr] combinationally; rvalid = !empty; a word written into an empty FIFO appears one cycle after the write edge.
REQ-023 FWFT=0: on an accepted read, rdata is registered with mem[rd_ptr] and rvalid pulses high for exactly one cycle, one cycle after r_en; otherwise rdata holds and rvalid = 0.
REQ-024 Pointer wrap: after DEPTH writes and DEPTH reads the data order is preserved exactly (FIFO order, no loss or duplication).

Reset
REQ-025 rst_n low SHALL asynchronously clear wr_ptr, rd_ptr and count, giving empty=1, full=0, almost_empty=1, almost_full=0, rvalid=0, rdata=0 (FWFT=0), overflow=0 and underflow=0.
REQ-026 Memory contents are not reset; reset mid-operation discards all stored words, and requests coinciding with reset are ignored.
REQ-027 Reset de-assertion is used without internal synchronisation; the first accepted request is on the first clk edge with rst_n high.

Configuration
REQ-028 Macro SYNC_FIFO_ERR_EN defined: overflow sets on a dropped write and underflow on an ignored read, both sticky until err_clr=1 for a cycle; a set request in the same cycle as err_clr wins.
REQ-029 Macro SYNC_FIFO_ERR_EN undefined: the overflow, underflow and err_clr ports and their logic are absent; all other behaviour is identical.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, AF_THRESH=3, AE_THRESH=1)
REQ-030 Write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_empty drops at count 2; almost_full rises at 3; full at 4; read 4 words -> 0x11..0x44 in order, empty=1.
REQ-031 Full FIFO, write 0x55 -> count stays 4, contents unchanged, overflow=1 (ERR_EN); err_clr pulse -> overflow=0.
REQ-032 Empty FIFO, r_en=1 -> count 0, rvalid=0, underflow=1 (ERR_EN); simultaneous w_en=1 with 0xA5 -> count 1, FWFT rdata=0xA5 next cycle.
REQ-033 Count 2, w_en=r_en=1 for 10 cycles with an incrementing pattern -> count stays 2, pointers wrap, output order exact.
REQ-034 FWFT=0: count 1 holding 0x3C, r_en pulse -> rdata=0x3C and rvalid=1 exactly one cycle later, then rvalid=0.
REQ-035 Count 3, assert rst_n=0 between clock edges -> outputs take reset values immediately; after release, write 0x77 then read -> 0x77.
